// File: rtl/alu_pkg.sv
// Shared types and golden arithmetic for miniALU result checking.
// Benches and the checker both call alu_golden, so all of them use the same definition of "correct".
package alu_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SHL = 1'b1;
    localparam int   RES_W  = 20;

    typedef enum logic [1:0] {
        IDLE,
        CHECK,
        DONE
    } chk_state_t;

    // The worst-case shift, 15<<15, needs 19 bits, so RES_W holds every result.
    function automatic logic [RES_W-1:0] alu_golden(
        input logic [3:0] a,
        input logic [3:0] b,
        input logic       op
    );
        logic [RES_W-1:0] r;
        if (op == OP_ADD) begin
            r = RES_W'(a) + RES_W'(b);
        end else begin
            r = RES_W'(a) << b;
        end
        return r;
    endfunction

endpackage

// File: rtl/alu_golden_model.sv
// Combinational reference result for one miniALU vector.
// Zero latency, no flow control.
module alu_golden_model #(
    parameter int RES_W = 20
) (
    input  logic [3:0]       a,
    input  logic [3:0]       b,
    input  logic             op,
    output logic [RES_W-1:0] golden
);
    import alu_pkg::*;

    assign golden = RES_W'(alu_golden(a, b, op));

endmodule

// File: rtl/alu_result_checker.sv
// Checks miniALU results against the golden model, counts vectors and errors, and latches the first failure.
// Counters reflect a sample two edges after it is presented; there is no backpressure, so a sample is accepted every cycle.
module alu_result_checker #(
    parameter int NUM_VECTORS = 512,
    parameter int RES_W       = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             in_valid,
    input  logic [3:0]       in_a,
    input  logic [3:0]       in_b,
    input  logic             in_op,
    input  logic [RES_W-1:0] in_result,
    output logic [9:0]       vec_count,
    output logic [9:0]       err_count,
    output logic             first_err,
    output logic [3:0]       first_err_a,
    output logic [3:0]       first_err_b,
    output logic             first_err_op,
    output logic [RES_W-1:0] first_err_got,
    output logic             done,
    output logic             pass
);
    import alu_pkg::*;

    localparam logic [9:0] NV      = 10'(NUM_VECTORS);
    localparam logic [9:0] ERR_MAX = 10'h3FF;

    chk_state_t       state_q, state_d;
    logic             vld_q, vld_d;
    logic [3:0]       a_q, a_d, b_q, b_d;
    logic             op_q, op_d;
    logic [RES_W-1:0] res_q, res_d;
    logic [9:0]       vec_count_q, vec_count_d;
    logic [9:0]       err_count_q, err_count_d;
    logic             first_err_q, first_err_d;
    logic [3:0]       fe_a_q, fe_a_d, fe_b_q, fe_b_d;
    logic             fe_op_q, fe_op_d;
    logic [RES_W-1:0] fe_got_q, fe_got_d;
    logic             done_q, done_d;
    logic [RES_W-1:0] golden;
    logic             mismatch;
    logic             do_check;

    alu_golden_model #(.RES_W(RES_W)) u_golden (
        .a      (a_q),
        .b      (b_q),
        .op     (op_q),
        .golden (golden)
    );

    // Case inequality so an X/Z result is scored as a miscompare.
    assign mismatch = (res_q !== golden);

    always_comb begin
        state_d     = state_q;
        vld_d       = in_valid;
        a_d         = in_a;
        b_d         = in_b;
        op_d        = in_op;
        res_d       = in_result;
        vec_count_d = vec_count_q;
        err_count_d = err_count_q;
        first_err_d = first_err_q;
        fe_a_d      = fe_a_q;
        fe_b_d      = fe_b_q;
        fe_op_d     = fe_op_q;
        fe_got_d    = fe_got_q;
        done_d      = done_q;
        do_check    = 1'b0;

        case (state_q)
            IDLE:    do_check = vld_q;
            CHECK:   do_check = vld_q;
            DONE:    do_check = 1'b0;
            default: do_check = 1'b0;
        endcase

        if (do_check) begin
            vec_count_d = vec_count_q + 10'd1;
            state_d     = CHECK;
            if (mismatch) begin
                if (err_count_q != ERR_MAX) begin
                    err_count_d = err_count_q + 10'd1;
                end
                if (!first_err_q) begin
                    first_err_d = 1'b1;
                    fe_a_d      = a_q;
                    fe_b_d      = b_q;
                    fe_op_d     = op_q;
                    fe_got_d    = res_q;
                end
            end
            if (vec_count_d == NV) begin
                state_d = DONE;
                done_d  = 1'b1;
            end
        end

        // A restart drops both the captured sample and the one arriving now.
        if (clear) begin
            state_d     = IDLE;
            vld_d       = 1'b0;
            a_d         = '0;
            b_d         = '0;
            op_d        = 1'b0;
            res_d       = '0;
            vec_count_d = '0;
            err_count_d = '0;
            first_err_d = 1'b0;
            fe_a_d      = '0;
            fe_b_d      = '0;
            fe_op_d     = 1'b0;
            fe_got_d    = '0;
            done_d      = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            vld_q       <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= 1'b0;
            res_q       <= '0;
            vec_count_q <= '0;
            err_count_q <= '0;
            first_err_q <= 1'b0;
            fe_a_q      <= '0;
            fe_b_q      <= '0;
            fe_op_q     <= 1'b0;
            fe_got_q    <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            vld_q       <= vld_d;
            a_q         <= a_d;
            b_q         <= b_d;
            op_q        <= op_d;
            res_q       <= res_d;
            vec_count_q <= vec_count_d;
            err_count_q <= err_count_d;
            first_err_q <= first_err_d;
            fe_a_q      <= fe_a_d;
            fe_b_q      <= fe_b_d;
            fe_op_q     <= fe_op_d;
            fe_got_q    <= fe_got_d;
            done_q      <= done_d;
        end
    end

    assign vec_count     = vec_count_q;
    assign err_count     = err_count_q;
    assign first_err     = first_err_q;
    assign first_err_a   = fe_a_q;
    assign first_err_b   = fe_b_q;
    assign first_err_op  = fe_op_q;
    assign first_err_got = fe_got_q;
    assign done          = done_q;
    assign pass          = done_q && (err_count_q == 10'd0);

endmodule

// File: tb/tb_alu_result_checker.sv
// Directed and randomized sweeps of alu_result_checker scored against a behavioural sweep model.
module tb_alu_result_checker;

    localparam int NV = 512;
    localparam int RW = 20;

    logic          clk = 1'b0;
    logic          rst;
    logic          clear;
    logic          in_valid;
    logic [3:0]    in_a, in_b;
    logic          in_op;
    logic [RW-1:0] in_result;
    logic [9:0]    vec_count, err_count;
    logic          first_err;
    logic [3:0]    first_err_a, first_err_b;
    logic          first_err_op;
    logic [RW-1:0] first_err_got;
    logic          done, pass;

    alu_result_checker #(.NUM_VECTORS(NV), .RES_W(RW)) dut (
        .clk           (clk),
        .rst           (rst),
        .clear         (clear),
        .in_valid      (in_valid),
        .in_a          (in_a),
        .in_b          (in_b),
        .in_op         (in_op),
        .in_result     (in_result),
        .vec_count     (vec_count),
        .err_count     (err_count),
        .first_err     (first_err),
        .first_err_a   (first_err_a),
        .first_err_b   (first_err_b),
        .first_err_op  (first_err_op),
        .first_err_got (first_err_got),
        .done          (done),
        .pass          (pass)
    );

    always #5 clk = ~clk;

    int n_vec      = 0;
    int miscompare = 0;
    int n_checks   = 0;

    // Sweep model: what an observer of the whole sweep expects.
    int m_vec, m_err, m_fa, m_fb, m_fop, m_fgot;
    bit m_fe, m_done;

    task automatic model_reset();
        m_vec = 0; m_err = 0; m_fe = 0; m_fa = 0; m_fb = 0; m_fop = 0; m_fgot = 0; m_done = 0;
    endtask

    function automatic int ref_result(int a, int b, int op);
        return (op != 0) ? (a * (1 << b)) : (a + b);
    endfunction

    task automatic chk(string tag, int got, int exp);
        n_checks++;
        assert (got === exp) else begin
            miscompare++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_all(string tag);
        chk({tag, ".vec_count"}, int'(vec_count), m_vec);
        chk({tag, ".err_count"}, int'(err_count), m_err);
        chk({tag, ".first_err"}, int'(first_err), int'(m_fe));
        chk({tag, ".first_err_a"}, int'(first_err_a), m_fa);
        chk({tag, ".first_err_b"}, int'(first_err_b), m_fb);
        chk({tag, ".first_err_op"}, int'(first_err_op), m_fop);
        chk({tag, ".first_err_got"}, int'(first_err_got), m_fgot);
        chk({tag, ".done"}, int'(done), int'(m_done));
        chk({tag, ".pass"}, int'(pass), int'(m_done && m_err == 0));
    endtask

    // One clock cycle of stimulus; the model scores the sample at once.
    task automatic drive(bit v, bit clr, int a, int b, int op, int res);
        in_valid  = v;
        clear     = clr;
        in_a      = 4'(a);
        in_b      = 4'(b);
        in_op     = 1'(op);
        in_result = RW'(res);
        if (v) n_vec++;
        if (clr) begin
            model_reset();
        end else if (v && !m_done) begin
            m_vec++;
            if (res != ref_result(a, b, op)) begin
                if (m_err < 1023) m_err++;
                if (!m_fe) begin
                    m_fe = 1; m_fa = a; m_fb = b; m_fop = op; m_fgot = res;
                end
            end
            if (m_vec == NV) m_done = 1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) begin
            drive(0, 0, $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 1), $urandom);
        end
    endtask

    // fault 1: (3,2,1) reads 0. fault 2: (1,1,0) and (15,15,1) corrupted.
    task automatic sweep(int count, int fault, int gap_pct, int corrupt_pct);
        for (int i = 0; i < count; i++) begin
            int a, b, op, res;
            while ($urandom_range(0, 99) < gap_pct) idle(1);
            op  = (i >> 8) & 1;
            a   = (i >> 4) & 15;
            b   = i & 15;
            res = ref_result(a, b, op);
            if (fault == 1 && a == 3 && b == 2 && op == 1) res = 0;
            if (fault == 2 && a == 1 && b == 1 && op == 0) res = 7;
            if (fault == 2 && a == 15 && b == 15 && op == 1) res = 5;
            if ($urandom_range(0, 99) < corrupt_pct) res = res ^ $urandom_range(1, (1 << RW) - 1);
            drive(1, 0, a, b, op, res);
        end
    endtask

    initial begin
        model_reset();
        rst = 1; clear = 0; in_valid = 0; in_a = 0; in_b = 0; in_op = 0; in_result = 0;
        #1;
        check_all("reset");
        repeat (2) @(posedge clk);
        #1;
        rst = 0;

        sweep(NV, 0, 0, 0);
        idle(2);
        check_all("clean_b2b");

        for (int i = 0; i < 4; i++) drive(1, 0, 3, 2, 1, 99);
        idle(2);
        check_all("after_done");

        idle(1);
        drive(1, 1, 3, 2, 1, 0);
        check_all("clear_drop");
        idle(2);
        check_all("clear_hold");

        sweep(NV, 1, 0, 0);
        idle(2);
        check_all("fault_one");

        drive(0, 1, 0, 0, 0, 0);
        sweep(NV, 2, 0, 0);
        idle(2);
        check_all("fault_two");

        drive(0, 1, 0, 0, 0, 0);
        sweep(100, 0, 0, 0);
        idle(2);
        check_all("mid_100");
        sweep(5, 1, 0, 0);
        rst = 1;
        model_reset();
        #2;
        check_all("rst_async");
        @(posedge clk);
        #1;
        rst = 0;
        sweep(NV, 0, 0, 0);
        idle(2);
        check_all("after_rst");

        drive(0, 1, 0, 0, 0, 0);
        sweep(NV, 0, 70, 0);
        idle(2);
        check_all("gappy_clean");

        drive(0, 1, 0, 0, 0, 0);
        sweep(NV, 0, 50, 5);
        idle(2);
        check_all("gappy_random_faults");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, miscompare);
        $finish;
    end

endmodule

// File: doc/alu_result_checker.md
# alu_result_checker

Synthesizable response checker that sits on the output side of `miniALU` during exhaustive sweeps. Each valid cycle it samples one applied vector (`inA`, `inB`, `operation`) and the ALU's `result`, and recomputes the golden value. It counts vectors and mismatches, and latches the first failing vector. After the configured number of vectors it raises `done` and a `pass` verdict, so a sweep can be judged in hardware (LEDs/7-seg) rather than by waveform inspection.

## Interface
Parameters:
- `NUM_VECTORS`, default 512: vectors per sweep (16 × 16 × 2); legal range 1..1023.
- `RES_W`, default 20: width of the ALU result bus.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `clear`  in  1  synchronous restart; returns to IDLE and zeroes all counters and latches.
- `in_valid`  in  1  sample qualifier for the vector below.
- `in_a`  in  4  applied `inA`.
- `in_b`  in  4  applied `inB`.
- `in_op`  in  1  applied `operation`.
- `in_result`  in  RES_W  ALU `result` for that vector.
- `vec_count`  out  10  vectors checked.
- `err_count`  out  10  mismatches seen, saturating at 1023.
- `first_err`  out  1  a mismatch has been latched.
- `first_err_a`, `first_err_b`  out  4  operands of the first mismatch.
- `first_err_op`  out  1  op of the first mismatch.
- `first_err_got`  out  RES_W  `result` of the first mismatch.
- `done`  out  1  sweep complete, sticky.
- `pass`  out  1  `done` and `err_count == 0`.

## Operation
- Golden model:
  - op 0: `in_a + in_b`, zero-extended to RES_W.
  - op 1: `in_a << in_b`, computed at RES_W width; maximum value 15<<15 = 491520, which fits in 19 bits.
- States:
  - IDLE: after reset or `clear`. Moves to CHECK on the first `in_valid`; that sample is checked.
  - CHECK: each `in_valid` sample is checked.
  - DONE: entered when the check of vector number NUM_VECTORS completes.
- In DONE, `in_valid` is ignored and no counter changes. Only `rst` or `clear` leaves DONE.
- Check, per sample:
  - `vec_count` increments by 1.
  - On mismatch, `err_count` increments by 1, saturating at 1023.
  - If `first_err` is 0, the sample fields are latched and `first_err` is set. Later mismatches never overwrite the latch.
- X/Z on `in_result` counts as a mismatch; use a case-inequality compare in the golden path.
- Simultaneous `clear` and `in_valid`: `clear` wins and the sample is dropped.
- `rst` mid-sweep: all outputs return to their reset values immediately (asynchronous); no partial state survives.

## Timing
- Input registers capture `in_*` and `in_valid` at the edge. Compare and counter update happen at the following edge, so outputs reflect a sample 2 edges after it is presented.
- Back-to-back valid every cycle is fully supported; there is no backpressure.
- `done` and `pass` assert at the same edge that `vec_count` reaches NUM_VECTORS.
- Reset value of every output is 0: `vec_count`, `err_count`, `first_err*`, `done`, `pass`.
- `clear` takes effect at the next edge. Outputs read 0 one edge later, and the input pipeline stage is flushed too.
- Gaps in `in_valid` of any length are allowed. Counters hold during gaps.

## Structure
- Package `alu_pkg`:
  - `OP_ADD = 1'b0`, `OP_SHL = 1'b1`.
  - `RES_W = 20`.
  - State enum `chk_state_t {IDLE, CHECK, DONE}`.
  - Function `alu_golden(a, b, op)`. The same function is used by benches.
- One sub-module, `alu_golden_model`: a combinational golden-result unit wrapping `alu_golden`. It keeps the reference arithmetic separately testable.
- The top level holds the input pipeline register, the FSM, the counters and the first-error latch.

## Test plan
- Exhaustive sweep against a correct `miniALU`, 512 valid cycles back-to-back → `done=1`, `pass=1`, `vec_count=512`, `err_count=0`, `first_err=0`.
- Inject a fault: `result` forced to 0 for a=3, b=2, op=1 (expected 12) → `first_err_a=3`, `first_err_b=2`, `first_err_op=1`, `first_err_got=0`, `err_count=1`, `pass=0`.
- Two faults, at (1,1,0) and then (15,15,1) → the latch holds (1,1,0), `err_count=2`.
- Assert `rst` after 100 vectors → all outputs 0 immediately. A fresh 512-vector sweep then passes.
- Assert `clear` in the same cycle as a valid mismatching sample → sample dropped, counters 0 after one edge. Extra valid samples sent after DONE do not change `vec_count` (stays 512).
- Random gaps (`in_valid` duty ~30%) over a full sweep → the results are identical to the back-to-back case.
